// File: rtl/group_tile_emit_fp16.sv
// Ping-pong group buffer that serialises each accepted group into a
// one-tile-per-cycle stream (no backpressure), flagging the final tile.
module group_tile_emit_fp16 #(
  parameter  int DW              = 16,
  parameter  int H_TILE          = 1,
  parameter  int P_TILE          = 1,
  parameter  int TILES_PER_GROUP = 8,
  localparam int HPW             = H_TILE * P_TILE * DW,
  localparam int IW              = (TILES_PER_GROUP > 1) ? $clog2(TILES_PER_GROUP) : 1
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           grp_valid_i,
  output logic                           grp_ready_o,
  input  logic [TILES_PER_GROUP*HPW-1:0] grp_data_i,
  input  logic                           hold_i,
  output logic                           tile_valid_o,
  output logic [HPW-1:0]                 tile_o,
  output logic                           tile_last_o,
  output logic [IW-1:0]                  tile_idx_o,
  output logic                           busy_o
);

  localparam int              GW     = TILES_PER_GROUP * HPW;
  localparam logic [IW-1:0]   K_LAST = IW'(TILES_PER_GROUP - 1);

  typedef enum logic {
    S_IDLE,
    S_STREAM
  } state_t;

  state_t         r_state;
  state_t         w_state_nxt;

  logic [GW-1:0]  r_slot [2];
  logic           r_wptr;
  logic           r_rptr;
  logic [1:0]     r_occ;
  logic [IW-1:0]  r_k;
  logic [HPW-1:0] r_tile;
  logic           r_last;
  logic [IW-1:0]  r_idx;

  logic           w_accept;
  logic           w_emit;
  logic           w_free;
  logic [HPW-1:0] w_tile_sel;

  // Ready looks only at pre-edge occupancy, so a slot freeing this edge
  // cannot be refilled on the same edge.
  assign grp_ready_o = (r_occ != 2'd2);
  assign w_accept    = grp_valid_i && grp_ready_o;

  // r_state records whether a tile was issued on the previous edge,
  // which is exactly the registered tile_valid_o.
  always_comb begin
    w_state_nxt = S_IDLE;
    w_emit      = 1'b0;
    if ((r_occ != 2'd0) && !hold_i) begin
      w_state_nxt = S_STREAM;
      w_emit      = 1'b1;
    end
  end

  assign w_free     = w_emit && (r_k == K_LAST);
  assign w_tile_sel = r_slot[r_rptr][r_k*HPW +: HPW];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Slot payload needs no reset: occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_slot[r_wptr] <= grp_data_i;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr <= 1'b0;
      r_rptr <= 1'b0;
      r_occ  <= 2'd0;
      r_k    <= '0;
      r_tile <= '0;
      r_last <= 1'b0;
      r_idx  <= '0;
    end else begin
      if (w_accept) begin
        r_wptr <= ~r_wptr;
      end

      case ({w_accept, w_free})
        2'b10:   r_occ <= r_occ + 2'd1;
        2'b01:   r_occ <= r_occ - 2'd1;
        default: r_occ <= r_occ;
      endcase

      if (w_emit) begin
        r_tile <= w_tile_sel;
        r_idx  <= r_k;
        r_last <= (r_k == K_LAST);
        if (r_k == K_LAST) begin
          r_k    <= '0;
          r_rptr <= ~r_rptr;
        end else begin
          r_k <= r_k + 1'b1;
        end
      end else begin
        r_last <= 1'b0;
      end
    end
  end

  assign tile_valid_o = (r_state == S_STREAM);
  assign tile_o       = r_tile;
  assign tile_last_o  = r_last;
  assign tile_idx_o   = r_idx;
  assign busy_o       = (r_occ != 2'd0) || tile_valid_o;

endmodule

// File: tb/tb_group_tile_emit_fp16.sv
// Bench for group_tile_emit_fp16: an 8-tile and a 1-tile instance share stimulus,
// each compared every cycle against a queue-based model of the tile stream.
module tb_group_tile_emit_fp16;

  localparam int DW  = 16;
  localparam int TPG = 8;
  localparam int GW  = TPG * DW;

  logic          clk;
  logic          rst;
  logic          vld;
  logic          hold;
  logic [GW-1:0] data;

  logic          rdy8, tv8, last8, busy8;
  logic [DW-1:0] tile8;
  logic [2:0]    idx8;
  logic          rdy1, tv1, last1, busy1;
  logic [DW-1:0] tile1;
  logic [0:0]    idx1;

  group_tile_emit_fp16 #(.DW(DW), .H_TILE(1), .P_TILE(1), .TILES_PER_GROUP(TPG)) u_dut8 (
    .clk(clk), .rst(rst), .grp_valid_i(vld), .grp_ready_o(rdy8), .grp_data_i(data),
    .hold_i(hold), .tile_valid_o(tv8), .tile_o(tile8), .tile_last_o(last8),
    .tile_idx_o(idx8), .busy_o(busy8)
  );

  group_tile_emit_fp16 #(.DW(DW), .H_TILE(1), .P_TILE(1), .TILES_PER_GROUP(1)) u_dut1 (
    .clk(clk), .rst(rst), .grp_valid_i(vld), .grp_ready_o(rdy1), .grp_data_i(data[DW-1:0]),
    .hold_i(hold), .tile_valid_o(tv1), .tile_o(tile1), .tile_last_o(last1),
    .tile_idx_o(idx1), .busy_o(busy1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  // Reference: FIFO of pending groups plus a cursor into the head group.
  logic [GW-1:0] q8[$];
  logic [DW-1:0] q1[$];
  int            k8;
  logic          ev8, el8, ev1, el1;
  logic [DW-1:0] et8, et1;
  int            ei8;
  int            nacc8;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_step();
    logic          acc8, acc1;
    logic [GW-1:0] g;
    if (rst) begin
      q8.delete(); q1.delete();
      k8 = 0;
      ev8 = 0; el8 = 0; et8 = '0; ei8 = 0;
      ev1 = 0; el1 = 0; et1 = '0;
    end else begin
      acc8 = vld && (q8.size() < 2);
      acc1 = vld && (q1.size() < 2);
      if (q8.size() > 0 && !hold) begin
        g   = q8[0];
        et8 = g[k8*DW +: DW];
        ei8 = k8;
        ev8 = 1; el8 = (k8 == TPG-1);
        if (k8 == TPG-1) begin
          k8 = 0;
          void'(q8.pop_front());
        end else begin
          k8++;
        end
      end else begin
        ev8 = 0; el8 = 0;
      end
      if (q1.size() > 0 && !hold) begin
        et1 = q1.pop_front();
        ev1 = 1; el1 = 1;
      end else begin
        ev1 = 0; el1 = 0;
      end
      if (acc8) begin
        q8.push_back(data);
        nacc8++;
      end
      if (acc1) q1.push_back(data[DW-1:0]);
    end
  endtask

  task automatic check_all();
    check_eq("rdy8",  rdy8,  q8.size() < 2);
    check_eq("valid8", tv8,  ev8);
    check_eq("last8", last8, el8);
    check_eq("tile8", tile8, et8);
    check_eq("idx8",  idx8,  ei8[2:0]);
    check_eq("busy8", busy8, (q8.size() != 0) || ev8);
    check_eq("rdy1",  rdy1,  q1.size() < 2);
    check_eq("valid1", tv1,  ev1);
    check_eq("last1", last1, el1);
    check_eq("tile1", tile1, et1);
    check_eq("idx1",  idx1,  1'b0);
    check_eq("busy1", busy1, (q1.size() != 0) || ev1);
  endtask

  task automatic cyc(input logic r, input logic v, input logic h, input logic [GW-1:0] d);
    rst = r; vld = v; hold = h; data = d;
    model_step();
    @(posedge clk);
    @(negedge clk);
    check_all();
  endtask

  function automatic logic [GW-1:0] ramp(input logic [DW-1:0] base);
    logic [GW-1:0] g;
    for (int unsigned t = 0; t < TPG; t++) g[t*DW +: DW] = base + DW'(t);
    return g;
  endfunction

  function automatic logic [GW-1:0] rnd_grp();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  initial begin
    rst = 1; vld = 0; hold = 0; data = '0; nacc8 = 0;
    @(negedge clk);
    cyc(1, 0, 0, '0);
    cyc(1, 0, 0, '0);

    // Single ramp group, then drain.
    cyc(0, 1, 0, ramp(16'h3C00));
    for (int i = 0; i < 10; i++) cyc(0, 0, 0, '0);

    // Three groups offered continuously until all accepted.
    nacc8 = 0;
    for (int i = 0; i < 30; i++) cyc(0, nacc8 < 3, 0, ramp(16'h4000 + 16'(nacc8*16)));

    // Hold for three cycles mid-group.
    cyc(0, 1, 0, ramp(16'h3C00));
    for (int i = 1; i < 14; i++) cyc(0, 0, (i >= 3 && i <= 5), '0);

    // Reset in the middle of a group with a second one buffered.
    cyc(0, 1, 0, ramp(16'h1000));
    cyc(0, 1, 0, ramp(16'h2000));
    for (int i = 0; i < 4; i++) cyc(0, 0, 0, '0);
    cyc(1, 0, 0, '0);
    cyc(0, 1, 0, ramp(16'h5000));
    for (int i = 0; i < 10; i++) cyc(0, 0, 0, '0);

    // Randomized traffic.
    for (int i = 0; i < 800; i++)
      cyc(($urandom_range(0, 99) == 0), ($urandom_range(0, 2) != 0),
          ($urandom_range(0, 4) == 0), rnd_grp());
    for (int i = 0; i < 20; i++) cyc(0, 0, 0, '0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/group_tile_emit_fp16.md
Name: group_tile_emit_fp16

Overview:
Transmit side of the tiled group-accumulation stream. Accepts whole groups of TILES_PER_GROUP hp-vectors (H_TILE*P_TILE lanes of DW bits) through a valid/ready handshake. Buffers up to two groups (ping-pong). Serialises each group onto a no-backpressure tile stream, one tile per cycle, marking the final tile with last. The stream drives the group accumulator's valid/tile/last inputs directly.

Parameters:
DW, 16, bits per fp16 element
H_TILE, 1, heads per tile
P_TILE, 1, P-dim elements per tile
TILES_PER_GROUP, 8, tiles per group (N_TOTAL/N_TILE), >=1
(derived) HPW = H_TILE*P_TILE*DW; IW = max(1, clog2(TILES_PER_GROUP))

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous, active-high reset
grp_valid_i  in  1  group word valid
grp_ready_o  out  1  a buffer slot is free; transfer when grp_valid_i && grp_ready_o
grp_data_i  in  TILES_PER_GROUP*HPW  tile k occupies bits [k*HPW +: HPW]
hold_i  in  1  pause emission this cycle
tile_valid_o  out  1  tile_o valid (registered)
tile_o  out  HPW  current tile (registered)
tile_last_o  out  1  asserted with tile_valid_o on the group's final tile
tile_idx_o  out  IW  index of the current tile within its group
busy_o  out  1  any slot occupied or a tile is on the output

Behaviour:
- Reset (rst high at posedge): both slots are emptied and in-flight data is discarded. Read and write pointers and the tile counter are cleared. tile_valid_o=0, tile_last_o=0, tile_o=0, tile_idx_o=0, busy_o=0. grp_ready_o=1 from the first cycle after reset.
- Storage: two slots of TILES_PER_GROUP*HPW bits each. A 1-bit write pointer, a 1-bit read pointer, and occ[1:0] in the range 0..2.
- grp_ready_o = (occ != 2). It is combinational from registered occ and does not depend on grp_valid_i.
- Accept: on grp_valid_i && grp_ready_o, the slot at the write pointer is loaded and the write pointer toggles.
- Emit FSM:
  - IDLE: occ==0 or hold_i. tile_valid_o=0.
  - STREAM: occ>0 and !hold_i. On the next edge, tile_o is loaded from the read slot at index k, tile_valid_o=1, tile_idx_o=k, and tile_last_o=(k==TILES_PER_GROUP-1). k then increments.
  - When k==TILES_PER_GROUP-1 is emitted, k wraps to 0, the read pointer toggles, and the slot is freed. occ decrements on that same edge.
- Latency: a group accepted at edge t (emitter idle, hold_i low) produces tile 0 valid after edge t+1. Emission can never start from a slot on the same edge that loads it.
- Back-to-back groups: if the other slot is full when the last tile issues, its tile 0 follows on the next cycle with no bubble. Sustained throughput is 1 tile/cycle.
- Simultaneous accept and free on the same edge: occ is unchanged. Because grp_ready_o uses pre-edge occ, an offer while occ==2 is refused even if a slot frees on that edge.
- hold_i: while high, tile_valid_o=0 and tile_last_o=0, and k and the pointers hold. tile_o and tile_idx_o retain their last values. Emission resumes at the same k once hold_i drops. hold_i does not block accepts.
- Ordering: tiles leave in index order 0..TILES_PER_GROUP-1, and groups leave in acceptance order.
- TILES_PER_GROUP==1: every tile carries tile_last_o=1 and tile_idx_o=0.
- Data is passed bit-exact. The block does no arithmetic.
- busy_o = (occ!=0) || tile_valid_o.

Test Plan:
- Single group, TPG=8, tile k=16'h3C00+k: accept at cycle 0 -> tiles valid cycles 1..8 with data 3C00..3C07 and idx 0..7; last only at cycle 8; busy_o low from cycle 9.
- Three groups offered continuously -> grp_ready_o drops after two accepts. 24 consecutive valid cycles with no gap, last at cycles 8/16/24. Third group accepted on the first edge after occ<2.
- hold_i high for cycles 3-5 during a group -> tile_valid_o low for exactly those 3 cycles; tiles 0..7 all still delivered once in order, and last lands 3 cycles later.
- Instantiate with TPG=1, 4 groups back-to-back -> 4 consecutive valid cycles, each with tile_last_o=1 and tile_idx_o=0.
- Assert rst at tile 4 of group 1 with group 2 buffered -> next cycle all outputs are 0 and grp_ready_o=1. A new group then streams from tile 0 with no remnants.
- Loopback into the group accumulator (all-ones fp16 tiles 16'h3C00, TPG=8) -> one sum pulse per group equal to 16'h4800 (8.0).
